mac_vector_driver: RTL

MAC_VECTOR_DRIVER -- requirements
Module: mac_vector_driver

---
 rtl/mac_pkg.sv | 8 +
 rtl/mac_pair_buffer.sv | 38 +++
 rtl/mac_vector_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and widths for the MAC vector driver slice
package mac_pkg;
  localparam int OP_W        = 8;
  localparam int RES_W       = 16;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 15;
  typedef enum logic [2:0] {LOAD, CLEAR, STREAM, DRAIN, REPORT} state_t;
endpackage

// File: rtl/mac_pair_buffer.sv
// mac_pair_buffer: DEPTH-entry operand-pair store with write/read pointers
//   clk, reset     : clock, async active-high reset (pointers only)
//   we_i, wr_data_i: write {a,b} at the write pointer, then advance it
//   adv_i          : advance the read pointer after the current read
//   clr_i          : rewind both pointers for the next vector
//   rd_data_o      : pair at the registered read pointer
module mac_pair_buffer
  import mac_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic [2*OP_W-1:0]   wr_data_i,
  input  logic                adv_i,
  input  logic                clr_i,
  output logic [2*OP_W-1:0]   rd_data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [2*OP_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (we_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (adv_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  // Contents need no reset: a vector is always written before it is read.
  always_ff @(posedge clk)
    if (we_i) mem_q[wr_ptr_q] <= wr_data_i;
  assign rd_data_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/mac_vector_driver.sv
// mac_vector_driver: buffers a vector of operand pairs, streams it through a MAC, reports the dot product
//   in_valid/in_ready/in_a/in_b/in_last : upstream operand pairs
//   mac_clr/mac_a/mac_b/mac_valid       : drive the MAC
//   mac_f/mac_valid_out/mac_overflow    : MAC result and status
//   res_valid/res_ready/res_data/res_ovf/res_err/res_count : result handshake
module mac_vector_driver
  import mac_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_a,
  input  logic [OP_W-1:0]       in_b,
  input  logic                  in_last,
  output logic                  mac_clr,
  output logic [OP_W-1:0]       mac_a,
  output logic [OP_W-1:0]       mac_b,
  output logic                  mac_valid,
  input  logic [RES_W-1:0]      mac_f,
  input  logic                  mac_valid_out,
  input  logic                  mac_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [RES_W-1:0]      res_data,
  output logic                  res_ovf,
  output logic                  res_err,
  output logic [$clog2(DEPTH):0] res_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, sent_q, ret_q;
  logic [TW-1:0]     idle_q;
  logic [RES_W-1:0]  data_q;
  logic              ovf_q, err_q, clr_q;
  logic [2*OP_W-1:0] rd_data;
  logic              hs, ret_hit, timeout, accept_ret, done;
  assign hs         = in_valid && in_ready;
  assign ret_hit    = ret_q == count_q;
  assign timeout    = !mac_valid_out && idle_q == TW'(TIMEOUT - 1);
  // Returns past the vector length are dropped so the counter never wraps.
  assign accept_ret = mac_valid_out && (state_q == STREAM || state_q == DRAIN) && !ret_hit;
  assign done       = state_q == REPORT && res_ready;
  mac_pair_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .we_i      (hs),
    .wr_data_i ({in_a, in_b}),
    .adv_i     (mac_valid),
    .clr_i     (done),
    .rd_data_o (rd_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= LOAD;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (hs && (in_last || count_q == CW'(DEPTH - 1))) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (sent_q == count_q - 1'b1) state_d = DRAIN;
      DRAIN:   if (ret_hit || timeout) state_d = REPORT;
      REPORT:  if (res_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end
  always_comb begin
    in_ready  = state_q == LOAD && !reset;
    mac_valid = state_q == STREAM;
    mac_a     = mac_valid ? rd_data[2*OP_W-1:OP_W] : '0;
    mac_b     = mac_valid ? rd_data[OP_W-1:0] : '0;
    res_valid = state_q == REPORT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count_q <= '0;
      sent_q  <= '0;
      ret_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      clr_q <= state_d == CLEAR;
      if (hs) count_q <= count_q + 1'b1;
      if (state_q == CLEAR) begin
        data_q <= '0;
        ovf_q  <= 1'b0;
        err_q  <= 1'b0;
      end
      if (mac_valid) sent_q <= sent_q + 1'b1;
      if (accept_ret) begin
        ret_q  <= ret_q + 1'b1;
        data_q <= mac_f;
      end
      if (state_q == DRAIN) idle_q <= mac_valid_out ? '0 : idle_q + 1'b1;
      // The MAC overflow flag is sticky, so sampling it once on the way out is enough.
      if (state_q == DRAIN && state_d == REPORT) begin
        ovf_q <= mac_overflow;
        err_q <= !ret_hit;
      end
      if (done) begin
        count_q <= '0;
        sent_q  <= '0;
        ret_q   <= '0;
        idle_q  <= '0;
      end
    end
  assign mac_clr   = clr_q;
  assign res_data  = data_q;
  assign res_ovf   = ovf_q;
  assign res_err   = err_q;
  assign res_count = count_q;
endmodule
